// File: rtl/dcache_mem_controller_pkg.sv
// dcache_mem_controller_pkg: channel state encoding and consumer index width helper.
package dcache_mem_controller_pkg;
   typedef logic [2:0] chan_state_t;
   localparam chan_state_t IDLE           = 3'd0;
   localparam chan_state_t READ_WAITING   = 3'd1;
   localparam chan_state_t WRITE_WAITING  = 3'd2;
   localparam chan_state_t READ_RELAYING  = 3'd3;
   localparam chan_state_t WRITE_RELAYING = 3'd4;

   function automatic int consumer_idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/dcache_mem_channel.sv
// dcache_mem_channel: one memory channel, carries a granted consumer request through
// the memory handshake and relays the result until the consumer drops valid.
module dcache_mem_channel
   import dcache_mem_controller_pkg::*;
#(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 8,
   parameter int IDX_BITS  = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 grant,
   input  logic                 grant_write,
   input  logic [IDX_BITS-1:0]  grant_idx,
   input  logic [ADDR_BITS-1:0] grant_address,
   input  logic [DATA_BITS-1:0] grant_data,
   input  logic                 read_valid,
   input  logic                 write_valid,
   output logic                 idle,
   output logic [IDX_BITS-1:0]  idx,
   output logic                 read_ready,
   output logic                 write_ready,
   output logic [DATA_BITS-1:0] read_data,
   output logic                 mem_read_valid,
   output logic [ADDR_BITS-1:0] mem_read_address,
   input  logic                 mem_read_ready,
   input  logic [DATA_BITS-1:0] mem_read_data,
   output logic                 mem_write_valid,
   output logic [ADDR_BITS-1:0] mem_write_address,
   output logic [DATA_BITS-1:0] mem_write_data,
   input  logic                 mem_write_ready
);
   chan_state_t state;

   assign idle = state == IDLE;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state             <= IDLE;
         idx               <= '0;
         read_ready        <= 1'b0;
         write_ready       <= 1'b0;
         read_data         <= '0;
         mem_read_valid    <= 1'b0;
         mem_read_address  <= '0;
         mem_write_valid   <= 1'b0;
         mem_write_address <= '0;
         mem_write_data    <= '0;
      end else
         case (state)
            IDLE:
               if (grant) begin
                  idx <= grant_idx;
                  if (grant_write) begin
                     state             <= WRITE_WAITING;
                     mem_write_valid   <= 1'b1;
                     mem_write_address <= grant_address;
                     mem_write_data    <= grant_data;
                  end else begin
                     state            <= READ_WAITING;
                     mem_read_valid   <= 1'b1;
                     mem_read_address <= grant_address;
                  end
               end
            READ_WAITING:
               if (mem_read_ready) begin
                  mem_read_valid <= 1'b0;
                  read_ready     <= 1'b1;
                  read_data      <= mem_read_data;
                  state          <= READ_RELAYING;
               end
            WRITE_WAITING:
               if (mem_write_ready) begin
                  mem_write_valid <= 1'b0;
                  write_ready     <= 1'b1;
                  state           <= WRITE_RELAYING;
               end
            READ_RELAYING:
               if (!read_valid) begin
                  read_ready <= 1'b0;
                  read_data  <= '0;
                  state      <= IDLE;
               end
            WRITE_RELAYING:
               if (!write_valid) begin
                  write_ready <= 1'b0;
                  state       <= IDLE;
               end
            default: state <= IDLE;
         endcase
endmodule

// File: rtl/dcache_mem_controller.sv
// dcache_mem_controller: arbitrates dcache consumer lanes onto NUM_CHANNELS memory channels.
// Define DCACHE_MEM_CONTROLLER_RR_EN for a round-robin consumer scan instead of fixed priority.
module dcache_mem_controller
   import dcache_mem_controller_pkg::*;
#(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 8,
   parameter int NUM_CHANNELS  = 8
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_CONSUMERS-1:0]            consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]            consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0]  consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]            consumer_write_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_write_address,
   input  logic [NUM_CONSUMERS*DATA_BITS-1:0]  consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]            consumer_write_ready,
   output logic [NUM_CHANNELS-1:0]             mem_read_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]   mem_read_address,
   input  logic [NUM_CHANNELS-1:0]             mem_read_ready,
   input  logic [NUM_CHANNELS*DATA_BITS-1:0]   mem_read_data,
   output logic [NUM_CHANNELS-1:0]             mem_write_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]   mem_write_address,
   output logic [NUM_CHANNELS*DATA_BITS-1:0]   mem_write_data,
   input  logic [NUM_CHANNELS-1:0]             mem_write_ready
);
   localparam int IB = consumer_idx_bits(NUM_CONSUMERS);

   logic [NUM_CHANNELS-1:0]  ch_idle, ch_grant, ch_gwrite, ch_rready, ch_wready, ch_rvalid, ch_wvalid;
   logic [IB-1:0]            ch_gidx  [NUM_CHANNELS];
   logic [IB-1:0]            ch_idx   [NUM_CHANNELS];
   logic [ADDR_BITS-1:0]     ch_gaddr [NUM_CHANNELS];
   logic [DATA_BITS-1:0]     ch_gdata [NUM_CHANNELS];
   logic [DATA_BITS-1:0]     ch_rdata [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0] serving, eligible;

`ifdef DCACHE_MEM_CONTROLLER_RR_EN
   logic [IB-1:0] ptr, last;
   logic          any;

   always_ff @(posedge clk or negedge reset)
      if (!reset) ptr <= '0;
      else if (any) ptr <= IB'((int'(last) + 1) % NUM_CONSUMERS);
`endif

   assign eligible = (consumer_read_valid | consumer_write_valid) & ~serving;

   // claimed keeps a lane from being granted to two channels in the same cycle
   always_comb begin
      logic [NUM_CONSUMERS-1:0] claimed;
      int c;
      claimed = '0;
      c = 0;
`ifdef DCACHE_MEM_CONTROLLER_RR_EN
      last = ptr;
      any  = 1'b0;
`endif
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         ch_grant[k]  = 1'b0;
         ch_gwrite[k] = 1'b0;
         ch_gidx[k]   = '0;
         ch_gaddr[k]  = '0;
         ch_gdata[k]  = '0;
         for (int j = 0; j < NUM_CONSUMERS; j++) begin
`ifdef DCACHE_MEM_CONTROLLER_RR_EN
            c = (int'(ptr) + j) % NUM_CONSUMERS;
`else
            c = j;
`endif
            if (ch_idle[k] && !ch_grant[k] && eligible[c] && !claimed[c]) begin
               ch_grant[k]  = 1'b1;
               claimed[c]   = 1'b1;
               ch_gidx[k]   = IB'(c);
               ch_gwrite[k] = !consumer_read_valid[c];
               ch_gaddr[k]  = ch_gwrite[k] ? consumer_write_address[c*ADDR_BITS +: ADDR_BITS]
                                           : consumer_read_address[c*ADDR_BITS +: ADDR_BITS];
               ch_gdata[k]  = consumer_write_data[c*DATA_BITS +: DATA_BITS];
`ifdef DCACHE_MEM_CONTROLLER_RR_EN
               last = IB'(c);
               any  = 1'b1;
`endif
            end
         end
      end
   end

   always_comb begin
      serving              = '0;
      consumer_read_ready  = '0;
      consumer_write_ready = '0;
      consumer_read_data   = '0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         if (!ch_idle[k]) serving[ch_idx[k]] = 1'b1;
         if (ch_wready[k]) consumer_write_ready[ch_idx[k]] = 1'b1;
         if (ch_rready[k]) begin
            consumer_read_ready[ch_idx[k]] = 1'b1;
            consumer_read_data[int'(ch_idx[k])*DATA_BITS +: DATA_BITS] = ch_rdata[k];
         end
      end
   end

   for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
      assign ch_rvalid[k] = consumer_read_valid[ch_idx[k]];
      assign ch_wvalid[k] = consumer_write_valid[ch_idx[k]];

      dcache_mem_channel #(
         .ADDR_BITS(ADDR_BITS),
         .DATA_BITS(DATA_BITS),
         .IDX_BITS (IB)
      ) u_ch (
         .clk              (clk),
         .reset            (reset),
         .grant            (ch_grant[k]),
         .grant_write      (ch_gwrite[k]),
         .grant_idx        (ch_gidx[k]),
         .grant_address    (ch_gaddr[k]),
         .grant_data       (ch_gdata[k]),
         .read_valid       (ch_rvalid[k]),
         .write_valid      (ch_wvalid[k]),
         .idle             (ch_idle[k]),
         .idx              (ch_idx[k]),
         .read_ready       (ch_rready[k]),
         .write_ready      (ch_wready[k]),
         .read_data        (ch_rdata[k]),
         .mem_read_valid   (mem_read_valid[k]),
         .mem_read_address (mem_read_address[k*ADDR_BITS +: ADDR_BITS]),
         .mem_read_ready   (mem_read_ready[k]),
         .mem_read_data    (mem_read_data[k*DATA_BITS +: DATA_BITS]),
         .mem_write_valid  (mem_write_valid[k]),
         .mem_write_address(mem_write_address[k*ADDR_BITS +: ADDR_BITS]),
         .mem_write_data   (mem_write_data[k*DATA_BITS +: DATA_BITS]),
         .mem_write_ready  (mem_write_ready[k])
      );
   end
endmodule

// File: doc/dcache_mem_controller.md
Name: dcache_mem_controller

Overview:
- Memory-side responder for the dcache's controller interface.
- Accepts per-consumer read/write requests from the dcache, arbitrates them onto NUM_CHANNELS memory channels, and runs a valid/ready handshake with external memory.
- Returns ready/data to the dcache and holds it until the dcache drops valid (4-phase handshake).
- Sits between dcache and the global data memory.

Parameters:
- ADDR_BITS, 8, address width
- DATA_BITS, 8, data width
- NUM_CONSUMERS, 8, dcache request lanes
- NUM_CHANNELS, 8, concurrent memory channels (1..NUM_CONSUMERS)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- consumer_read_valid  in  NUM_CONSUMERS  dcache read request per lane
- consumer_read_address  in  [NUM_CONSUMERS] x ADDR_BITS  read address
- consumer_read_ready  out  NUM_CONSUMERS  read data valid, held until valid drops
- consumer_read_data  out  [NUM_CONSUMERS] x DATA_BITS  read data
- consumer_write_valid  in  NUM_CONSUMERS  dcache write request
- consumer_write_address  in  [NUM_CONSUMERS] x ADDR_BITS  write address
- consumer_write_data  in  [NUM_CONSUMERS] x DATA_BITS  write data
- consumer_write_ready  out  NUM_CONSUMERS  write complete, held until valid drops
- mem_read_valid  out  NUM_CHANNELS  memory read request
- mem_read_address  out  [NUM_CHANNELS] x ADDR_BITS  memory read address
- mem_read_ready  in  NUM_CHANNELS  memory read data valid
- mem_read_data  in  [NUM_CHANNELS] x DATA_BITS  memory read data
- mem_write_valid  out  NUM_CHANNELS  memory write request
- mem_write_address  out  [NUM_CHANNELS] x ADDR_BITS  memory write address
- mem_write_data  out  [NUM_CHANNELS] x DATA_BITS  memory write data
- mem_write_ready  in  NUM_CHANNELS  memory write accepted

Behaviour:
- Reset (reset low, asynchronous):
  - all outputs 0, all channels IDLE, all serving bits clear.
  - Reset asserted mid-transaction drops every outstanding request immediately; no replay after release.
- Per-channel FSM states: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
- IDLE:
  - The channel takes the first eligible consumer in scan order.
  - Eligible means valid is high and the consumer is not already being served or claimed this cycle.
  - Scan order is channels ascending and consumers ascending from index 0.
  - Read has priority over write for the same consumer; the write is taken on a later grant.
  - On grant the channel latches the consumer index and drives mem_*_valid/address (and data for writes) from the next edge. Request-to-memory latency is 1 cycle.
  - Each consumer lane is granted to at most one channel per cycle, enforced by a combinational claimed mask across channels.
- READ_WAITING:
  - Hold mem_read_valid/address stable until mem_read_ready is sampled high.
  - On that edge: mem_read_valid <= 0, consumer_read_ready[c] <= 1, consumer_read_data[c] <= mem_read_data, go to READ_RELAYING.
- WRITE_WAITING:
  - Same as READ_WAITING, using mem_write_ready and consumer_write_ready[c].
  - No data is returned.
- READ_RELAYING / WRITE_RELAYING:
  - Hold ready and data until the consumer's valid is sampled low.
  - On that edge: ready <= 0, data <= 0, serving bit cleared, go to IDLE.
  - The channel is re-grantable on the following edge.
- Memory ready while the channel is not WAITING is ignored.
- Consumer valid dropping while WAITING is ignored; the transaction completes and the relay ends on the next edge.
- More requests than channels: the remaining consumers stall with valid high until a channel frees. No request is lost.
- Addresses and data pass through unchanged; no width conversion.

Optional Feature:
- Macro: DCACHE_MEM_CONTROLLER_RR_EN.
- Defined:
  - Consumer scan starts at a registered round-robin pointer instead of 0, wrapping modulo NUM_CONSUMERS.
  - After any grant the pointer advances to (last granted consumer + 1) mod NUM_CONSUMERS.
  - The pointer resets to 0.
- Undefined: fixed priority, lowest index wins.

Decomposition:
- Package dcache_mem_controller_pkg holds:
  - channel state enum (3 bits)
  - derived CONSUMER_IDX_BITS = $clog2(NUM_CONSUMERS) width helper
- Sub-module dcache_mem_channel: one FSM per channel, generated NUM_CHANNELS times.
- The grant/claimed-mask arbiter and round-robin pointer stay in the top module.

Test Plan:
- Single read: lane 0 valid, addr 0xFF at cycle 1 -> mem_read_valid[0]=1, addr 0xFF at cycle 2. mem_read_ready=1, data 0xFF at cycle 2 -> consumer_read_ready[0]=1, data 0xFF at cycle 3, mem_read_valid[0]=0. Drop valid -> ready 0 next cycle.
- Mixed: lane 0 read 0xFF plus lane 1 write addr 0xF0, data 0xF0 in the same cycle -> channel 0 reads 0xFF, channel 1 writes 0xF0/0xF0. consumer_read_ready[0] and consumer_write_ready[1] rise one cycle after the respective memory ready.
- Same lane, read and write both valid -> read served first. The write is issued only after the read relay completes.
- NUM_CHANNELS=2 with lanes 0,1,2 reading -> lanes 0 and 1 issued immediately. Lane 2 issued one cycle after lane 0's relay ends, with its valid held throughout.
- Reset pulled low while a channel is WAITING with mem_read_valid=1 -> all outputs 0 immediately. After release, no memory request until a new consumer valid.
- With DCACHE_MEM_CONTROLLER_RR_EN and NUM_CHANNELS=1, lanes 0 and 1 held valid continuously -> grants alternate 0,1,0,1. Without the macro, lane 0 is re-granted whenever it re-requests.
